// File: rtl/score_cell_engine.sv
// Needleman-Wunsch fill engine: walks the N x N inner cells row-major, three
// cycles per cell, and emits each cell score with its traceback direction.
module score_cell_engine #(
    parameter int N           = 128,
    parameter int BitAddr     = $clog2(N + 1),
    parameter int addr_lenght = $clog2(((N + 1) * (N + 1)) - 1),
    parameter int MATCH       = 1,
    parameter int MISMATCH    = -1,
    parameter int GAP         = -2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    match,
    input  logic signed [8:0]       rd_data,
    output logic [BitAddr:0]        idx_i,
    output logic [BitAddr:0]        idx_j,
    output logic                    rd_en,
    output logic [addr_lenght:0]    rd_addr,
    output logic                    en_ins,
    output logic [BitAddr:0]        i,
    output logic [BitAddr:0]        j,
    output logic signed [8:0]       max,
    output logic [1:0]              dir,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CALC  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic signed [8:0]  MATCH_S    = 9'(MATCH);
    localparam logic signed [8:0]  MISMATCH_S = 9'(MISMATCH);
    localparam logic signed [8:0]  GAP_S      = 9'(GAP);
    localparam logic [8:0]         GAP_U      = 9'(GAP);
    localparam logic [BitAddr:0]   LAST_IDX   = (BitAddr + 1)'(N - 1);
    localparam logic [BitAddr:0]   IDX_ONE    = (BitAddr + 1)'(1);
    localparam logic [BitAddr:0]   IDX_ZERO   = (BitAddr + 1)'(0);
    localparam logic [addr_lenght:0] ROW_STRIDE = (addr_lenght + 1)'(N + 1);
    localparam logic [addr_lenght:0] ADDR_ONE   = (addr_lenght + 1)'(1);
    localparam logic [addr_lenght:0] ADDR_ZERO  = (addr_lenght + 1)'(0);

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic signed [8:0]      diag_r;
    logic signed [8:0]      left_r;
    logic signed [8:0]      d_s;
    logic signed [8:0]      u_s;
    logic signed [8:0]      l_s;
    logic signed [8:0]      max_s;
    logic [1:0]             dir_s;
    logic                   last_cell_s;
    logic [addr_lenght:0]   addr_s;

    // Column-0 boundary score GAP*(row+inc), computed modulo 2^9.
    function automatic logic signed [8:0] col0_score(input logic [BitAddr:0] row,
                                                     input logic [8:0]       inc);
        logic [8:0] prod;
        prod = GAP_U * (9'(row) + inc);
        return $signed(prod);
    endfunction

    assign last_cell_s = (idx_i == LAST_IDX) && (idx_j == LAST_IDX);
    assign addr_s      = (addr_lenght + 1)'(idx_j) + ADDR_ONE
                       + ROW_STRIDE * (addr_lenght + 1)'(idx_i);

    // Cell candidates and max selection; diagonal wins ties, then up.
    always_comb begin
        d_s = diag_r + (match ? MATCH_S : MISMATCH_S);
        u_s = rd_data + GAP_S;
        l_s = left_r + GAP_S;
        if ((d_s >= u_s) && (d_s >= l_s)) begin
            max_s = d_s;
            dir_s = 2'b00;
        end else if (u_s >= l_s) begin
            max_s = u_s;
            dir_s = 2'b01;
        end else begin
            max_s = l_s;
            dir_s = 2'b10;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: state_nxt_s = ST_WAIT;
            ST_WAIT:  state_nxt_s = ST_CALC;
            ST_CALC: begin
                if (last_cell_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_i   <= IDX_ZERO;
            idx_j   <= IDX_ZERO;
            rd_en   <= 1'b0;
            rd_addr <= ADDR_ZERO;
            en_ins  <= 1'b0;
            i       <= IDX_ZERO;
            j       <= IDX_ZERO;
            max     <= 9'sd0;
            dir     <= 2'b00;
            busy    <= 1'b0;
            done    <= 1'b0;
            diag_r  <= 9'sd0;
            left_r  <= 9'sd0;
        end else begin
            en_ins <= 1'b0;
            done   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        idx_i  <= IDX_ZERO;
                        idx_j  <= IDX_ZERO;
                        diag_r <= 9'sd0;
                        left_r <= GAP_S;
                        busy   <= 1'b1;
                    end else begin
                        busy   <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    rd_en   <= 1'b1;
                    rd_addr <= addr_s;
                end
                ST_WAIT: begin
                    rd_en <= 1'b0;
                end
                ST_CALC: begin
                    max    <= max_s;
                    dir    <= dir_s;
                    en_ins <= 1'b1;
                    i      <= idx_i;
                    j      <= idx_j;
                    done   <= last_cell_s;
                    if (idx_j < LAST_IDX) begin
                        idx_j  <= idx_j + IDX_ONE;
                        diag_r <= rd_data;
                        left_r <= max_s;
                    end else begin
                        // Next row starts on the arithmetic column-0 boundary.
                        idx_j  <= IDX_ZERO;
                        idx_i  <= idx_i + IDX_ONE;
                        diag_r <= col0_score(idx_i, 9'd1);
                        left_r <= col0_score(idx_i, 9'd2);
                    end
                end
                ST_DONE: begin
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_score_cell_engine.sv
// Scoreboard bench for score_cell_engine (N=4): a full-matrix reference model
// queues expected cells and fetch addresses; a monitor pops and compares them.
module tb_score_cell_engine;

    localparam int N    = 4;
    localparam int BA   = $clog2(N + 1);
    localparam int AL   = $clog2(((N + 1) * (N + 1)) - 1);
    localparam int GAP  = -2;
    localparam int MSZ  = (N + 1) * (N + 1);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 match;
    logic signed [8:0]    rd_data;
    logic [BA:0]          idx_i, idx_j, i, j;
    logic                 rd_en, en_ins, busy, done;
    logic [AL:0]          rd_addr;
    logic signed [8:0]    max;
    logic [1:0]           dir;

    score_cell_engine #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .match(match), .rd_data(rd_data),
        .idx_i(idx_i), .idx_j(idx_j), .rd_en(rd_en), .rd_addr(rd_addr),
        .en_ins(en_ins), .i(i), .j(j), .max(max), .dir(dir),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { int ci; int cj; int mx; int dr; } cell_t;
    typedef struct { int ci; int cj; int a; } fetch_t;

    cell_t  exp_q[$];
    fetch_t addr_q[$];
    int     seq_a[N];
    int     seq_b[N];
    int     row0[N + 1];
    int     got_max[N][N];
    int     got_dir[N][N];
    int     prev_max[N][N];
    int     prev_dir[N][N];
    int     n_checks = 0;
    int     n_fail = 0;
    int     cyc = 0;
    int     accept_cyc = 0;
    int     last_en_cyc = 0;
    bit     first_pending = 1'b0;
    int     pulse_cnt = 0;

    logic signed [8:0] mem [0:MSZ-1];
    logic signed [8:0] img [0:MSZ-1];
    logic              load_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Comparator stand-in.
    always_comb begin
        match = 1'b0;
        if (int'(idx_i) < N && int'(idx_j) < N)
            match = (seq_a[int'(idx_i)] == seq_b[int'(idx_j)]);
    end

    // Score RAM: synchronous read, writes from en_ins, bulk image load.
    always @(posedge clk) begin
        if (load_req) mem <= img;
        else if (en_ins) mem[(int'(i) + 1) * (N + 1) + int'(j) + 1] <= max;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic chk_eq(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: full DP matrix from the recurrence, queued row-major.
    task automatic build_expect();
        int H[N + 1][N + 1];
        int d, u, l, best, s;
        for (int a = 0; a <= N; a++) begin
            H[0][a] = row0[a];
            H[a][0] = GAP * a;
        end
        H[0][0] = 0;
        for (int a = 1; a <= N; a++) begin
            for (int b = 1; b <= N; b++) begin
                s = (seq_a[a-1] == seq_b[b-1]) ? 1 : -1;
                d = H[a-1][b-1] + s;
                u = H[a-1][b] + GAP;
                l = H[a][b-1] + GAP;
                best = d;
                if (u > best) best = u;
                if (l > best) best = l;
                H[a][b] = best;
                exp_q.push_back('{a-1, b-1, best, (d == best) ? 0 : (u == best) ? 1 : 2});
                addr_q.push_back('{a-1, b-1, b + (N + 1) * (a - 1)});
            end
        end
        for (int k = 0; k < MSZ; k++) img[k] = 9'($urandom_range(0, 511));
        for (int a = 0; a <= N; a++) begin
            img[a] = 9'(row0[a]);
            img[a * (N + 1)] = 9'(GAP * a);
        end
        img[0] = 9'sd0;
    endtask

    task automatic load_ram();
        @(negedge clk); load_req = 1'b1;
        @(negedge clk); load_req = 1'b0;
    endtask

    task automatic set_seqs(input int mode);
        for (int k = 0; k < N; k++) begin
            if (mode == 0) begin seq_a[k] = 1; seq_b[k] = 1; end
            else if (mode == 1) begin seq_a[k] = 0; seq_b[k] = 1; end
            else begin seq_a[k] = int'($urandom_range(0, 3)); seq_b[k] = int'($urandom_range(0, 3)); end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        accept_cyc = cyc + 1;
        first_pending = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_eq("busy_after_start", int'(busy), 1);
    endtask

    task automatic run_pass(input bit extra_start);
        int  base;
        bit  seen;
        build_expect();
        load_ram();
        base = pulse_cnt;
        pulse_start();
        if (extra_start) begin
            repeat (10) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk_eq("done_seen", int'(seen), 1);
        @(negedge clk);
        chk_eq("busy_cleared", int'(busy), 0);
        chk_eq("pulse_count", pulse_cnt - base, N * N);
        chk_eq("queue_drained", exp_q.size(), 0);
    endtask

    // Monitor: pops expectations whenever the DUT fetches or writes a cell.
    always @(negedge clk) begin
        cell_t  c;
        fetch_t f;
        if (!rst) begin
            if (rd_en) begin
                chk_eq("fetch_expected", int'(addr_q.size() > 0), 1);
                if (addr_q.size() > 0) begin
                    f = addr_q.pop_front();
                    chk_eq("rd_addr", int'(rd_addr), f.a);
                    chk_eq("idx_i", int'(idx_i), f.ci);
                    chk_eq("idx_j", int'(idx_j), f.cj);
                end
            end
            if (en_ins) begin
                pulse_cnt++;
                chk_eq("en_ins_expected", int'(exp_q.size() > 0), 1);
                if (first_pending) begin
                    chk_eq("first_latency", cyc - accept_cyc, 3);
                    first_pending = 1'b0;
                end else begin
                    chk_eq("en_ins_spacing", cyc - last_en_cyc, 3);
                end
                last_en_cyc = cyc;
                if (exp_q.size() > 0) begin
                    c = exp_q.pop_front();
                    chk_eq("cell_i", int'(i), c.ci);
                    chk_eq("cell_j", int'(j), c.cj);
                    chk_eq("cell_max", int'(max), c.mx);
                    chk_eq("cell_dir", int'(dir), c.dr);
                end
                if (int'(i) < N && int'(j) < N) begin
                    got_max[int'(i)][int'(j)] = int'(max);
                    got_dir[int'(i)][int'(j)] = int'(dir);
                end
            end
            if (done) begin
                chk_eq("done_with_en_ins", int'(en_ins), 1);
                chk_eq("done_last_cell", exp_q.size(), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_fetch;
        for (int k = 0; k <= N; k++) row0[k] = GAP * k;

        // Reset state
        #2;
        chk_eq("rst_en_ins", int'(en_ins), 0);
        chk_eq("rst_busy", int'(busy), 0);
        chk_eq("rst_done", int'(done), 0);
        chk_eq("rst_rd_en", int'(rd_en), 0);
        chk_eq("rst_rd_addr", int'(rd_addr), 0);
        chk_eq("rst_max", int'(max), 0);
        chk_eq("rst_dir", int'(dir), 0);
        @(negedge clk);
        rst = 1'b0;

        // All match on GAP boundaries
        set_seqs(0);
        run_pass(1'b0);
        for (int k = 0; k < N; k++) chk_eq("diag_kk_max", got_max[k][k], k + 1);
        chk_eq("match00_dir", got_dir[0][0], 0);

        // All mismatch
        set_seqs(1);
        run_pass(1'b0);
        chk_eq("mis00_max", got_max[0][0], -1);
        chk_eq("mis00_dir", got_dir[0][0], 0);
        chk_eq("mis01_max", got_max[0][1], -3);
        chk_eq("mis01_dir", got_dir[0][1], 0);

        // Random sequences, stray start while busy, then an identical rerun
        set_seqs(2);
        run_pass(1'b1);
        prev_max = got_max;
        prev_dir = got_dir;
        run_pass(1'b0);
        for (int a = 0; a < N; a++)
            for (int b = 0; b < N; b++) begin
                chk_eq("rerun_max", got_max[a][b], prev_max[a][b]);
                chk_eq("rerun_dir", got_dir[a][b], prev_dir[a][b]);
            end

        // Skewed upper-row data to force left and up/left-tie decisions
        set_seqs(0);
        row0[1] = -10; row0[2] = -10; row0[3] = -1; row0[4] = 5;
        run_pass(1'b0);
        chk_eq("skew00_max", got_max[0][0], 1);
        chk_eq("skew00_dir", got_dir[0][0], 0);
        chk_eq("skew01_max", got_max[0][1], -1);
        chk_eq("skew01_dir", got_dir[0][1], 2);
        chk_eq("skew02_max", got_max[0][2], -3);
        chk_eq("skew02_dir", got_dir[0][2], 1);
        chk_eq("skew03_max", got_max[0][3], 3);
        chk_eq("skew03_dir", got_dir[0][3], 1);
        for (int k = 0; k <= N; k++) row0[k] = GAP * k;

        // Reset during CALC of the third cell
        set_seqs(0);
        build_expect();
        load_ram();
        pulse_start();
        seen_fetch = 0;
        for (int k = 0; k < 100 && seen_fetch < 3; k++) begin
            @(negedge clk);
            if (rd_en) seen_fetch++;
        end
        chk_eq("abort_fetches_seen", seen_fetch, 3);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk_eq("abort_en_ins", int'(en_ins), 0);
        chk_eq("abort_busy", int'(busy), 0);
        chk_eq("abort_max", int'(max), 0);
        chk_eq("abort_dir", int'(dir), 0);
        chk_eq("abort_rd_addr", int'(rd_addr), 0);
        exp_q.delete();
        addr_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk_eq("abort_idle_busy", int'(busy), 0);

        // Fresh pass after the abort restarts from (0,0)
        set_seqs(2);
        run_pass(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
